// File: rtl/logic_array_pkg.sv
// rtl/logic_array_pkg.sv - shared op codes, mode constants and FSM state type
package logic_array_pkg;

  localparam logic [1:0] OP_OR   = 2'd0;
  localparam logic [1:0] OP_AND  = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;
  localparam logic [1:0] OP_XNOR = 2'd3;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_FOLD   = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

endpackage

// File: rtl/logic_lane.sv
// rtl/logic_lane.sv - one bitwise logic lane, operation fixed at elaboration
module logic_lane
  import logic_array_pkg::*;
#(
  parameter int         WIDTH = 8,
  parameter logic [1:0] OP    = OP_OR
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z
);

  // Select the lane operation; OP is constant so this reduces to one gate row
  always_comb begin
    case (OP)
      OP_OR:   z = x | y;
      OP_AND:  z = x & y;
      OP_XOR:  z = x ^ y;
      default: z = ~(x ^ y);
    endcase
  end

endmodule

// File: rtl/logic_array_stream.sv
// rtl/logic_array_stream.sv - streaming multi-lane logic unit with direct and fold modes
module logic_array_stream
  import logic_array_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NOPS  = 3,
  parameter int CNTW  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           b,
  input  logic [WIDTH-1:0]           c,
  input  logic                       mode,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NOPS-1:0][WIDTH-1:0] a,
  output logic [CNTW-1:0]            out_count
);

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  state_e                     state_q, state_d;
  logic                       pkt_mode_q, pkt_mode_d;
  logic [NOPS-1:0][WIDTH-1:0] acc_q, acc_d;
  logic [CNTW-1:0]            cnt_q, cnt_d;
  logic [NOPS-1:0][WIDTH-1:0] a_q, a_d;
  logic [CNTW-1:0]            count_q, count_d;
  logic                       valid_q, valid_d;

  logic [NOPS-1:0][WIDTH-1:0] beat_r;
  logic [NOPS-1:0][WIDTH-1:0] fold_r;
  logic [CNTW-1:0]            cnt_inc;
  logic                       accept;

  // Lane k: beat_r combines the operands, fold_r combines the beat into the accumulator
  for (genvar k = 0; k < NOPS; k++) begin : g_lane
    logic_lane #(.WIDTH(WIDTH), .OP(2'(k))) u_beat (
      .x(b),
      .y(c),
      .z(beat_r[k])
    );
    logic_lane #(.WIDTH(WIDTH), .OP(2'(k))) u_fold (
      .x(acc_q[k]),
      .y(beat_r[k]),
      .z(fold_r[k])
    );
  end

  // The output register can take a new result whenever it is empty or being drained
  assign in_ready  = !valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = valid_q;
  assign a         = a_q;
  assign out_count = count_q;

  // Beat count saturates at all-ones instead of wrapping
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

  // Next-state and result selection; anything not accepted holds its value
  always_comb begin
    state_d    = state_q;
    pkt_mode_d = pkt_mode_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    count_d    = count_q;
    valid_d    = valid_q;

    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (mode == MODE_DIRECT || in_last) begin
            a_d     = beat_r;
            count_d = CNT_ONE;
            valid_d = 1'b1;
          end else begin
            acc_d      = beat_r;
            cnt_d      = CNT_ONE;
            pkt_mode_d = mode;
            state_d    = ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          // Only fold packets open ACCUM; the mode input is not looked at here
          if (pkt_mode_q == MODE_FOLD) begin
            if (in_last) begin
              a_d     = fold_r;
              count_d = cnt_inc;
              valid_d = 1'b1;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = ST_IDLE;
            end else begin
              acc_d = fold_r;
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers; reset discards any open packet and clears the output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pkt_mode_q <= MODE_DIRECT;
      acc_q      <= '0;
      cnt_q      <= '0;
      a_q        <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pkt_mode_q <= pkt_mode_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: doc/logic_array_stream.md
LOGIC_ARRAY_STREAM -- requirements
Module: logic_array_stream

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each operand and of each result lane.
REQ-002 Parameter NOPS, default 3, legal 1..4: number of result lanes; lane k applies op k (0 OR, 1 AND, 2 XOR, 3 XNOR).
REQ-003 Parameter CNTW, default 8: width of the beat counter.
REQ-004 clk  input  1  single clock; all state on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  input beat valid.
REQ-007 in_ready  output  1  input beat accepted when in_valid && in_ready.
REQ-008 b  input  WIDTH  operand B.
REQ-009 c  input  WIDTH  operand C.
REQ-010 mode  input  1  0 direct, 1 fold; sampled on the first beat of a packet.
REQ-011 in_last  input  1  marks the final beat of a fold packet; ignored in direct mode.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  result consumed when out_valid && out_ready.
REQ-014 a  output  NOPS x WIDTH (packed [NOPS-1:0][WIDTH-1:0])  result lanes.
REQ-015 out_count  output  CNTW  number of beats folded into the current result (1 in direct mode).

Function
REQ-016 Per-beat lane result r_k = op_k(b, c), bitwise over WIDTH.
REQ-017 in_ready SHALL equal !out_valid || out_ready (combinational; no other input dependence).
REQ-018 Direct mode: an accepted beat loads a[k] = r_k and out_count = 1, and sets out_valid on the next edge (latency 1 cycle).
REQ-019 FSM states IDLE (no packet open) and ACCUM (fold packet open); reset state IDLE.
REQ-020 IDLE, accepted beat, mode=0: emit per REQ-018; stay IDLE.
REQ-021 IDLE, accepted beat, mode=1, in_last=0: acc[k] <= r_k, cnt <= 1, latch pkt_mode; go to ACCUM; no output.
REQ-022 IDLE, accepted beat, mode=1, in_last=1: single-beat packet; a[k] = r_k, out_count = 1, out_valid set; stay IDLE.
REQ-023 ACCUM, accepted beat, in_last=0: acc[k] <= op_k(acc[k], r_k); cnt increments; mode input ignored.
REQ-024 ACCUM, accepted beat, in_last=1: a[k] = op_k(acc[k], r_k), out_count = cnt+1, out_valid set; go to IDLE.
REQ-025 The beat counter SHALL saturate at 2^CNTW-1 and never wrap.
REQ-026 out_valid SHALL stay high and a/out_count SHALL stay stable until the handshake completes.
REQ-027 When a result is consumed and a new result-producing beat is accepted in the same cycle, the new result SHALL load with out_valid remaining high (no bubble).
REQ-028 Consuming a result without a new result-producing beat clears out_valid on the next edge.
REQ-029 Non-accepted cycles SHALL leave acc, cnt, state and outputs unchanged.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, out_valid 0, a all zeros, out_count 0, acc 0, cnt 0, independent of clk.
REQ-031 Reset asserted mid-packet SHALL discard the open packet; the first beat after release starts a new packet.
REQ-032 in_ready SHALL be 1 while in reset, since out_valid is 0; beats presented during reset SHALL NOT be accepted into state.

Structure
REQ-033 Package logic_array_pkg SHALL hold the op codes (OP_OR, OP_AND, OP_XOR, OP_XNOR), mode constants (MODE_DIRECT, MODE_FOLD), and the FSM state type.
REQ-034 Sub-module logic_lane (parameters WIDTH and OP; inputs x, y; output op(x, y)) SHALL be instantiated by generate for each lane k, for both r_k and the fold combine.

Verification
REQ-035 WIDTH=8, NOPS=4, direct mode, b=A5, c=5A, out_ready=1 -> next cycle a[0]=FF, a[1]=00, a[2]=FF, a[3]=00, out_count=1.
REQ-036 Fold: (A5,5A,last=0), then (0F,F0,last=1) -> one result: a[0]=FF, a[1]=00, a[2]=00, a[3]=FF, out_count=2; no output after the first beat.
REQ-037 Backpressure: out_ready=0 with a result held, second beat offered -> in_ready=0, a stable; raise out_ready -> both results delivered in order, with no gap between them.
REQ-038 CNTW=2, fold packet of 5 beats -> out_count=3 (saturated).
REQ-039 rst_n pulsed low after 2 beats of a fold packet, then one fold beat (FF,00,last=1) -> a[0]=FF, a[1]=00, out_count=1; reset clears the outputs asynchronously.
REQ-040 mode toggled to 0 on a middle beat of a fold packet -> the beat is still folded, and one result is emitted only at in_last.
